ins_cache_loader: RTL and testbench

- Fill engine for the instruction cache.
- When the cache controller enters its load state, this block fetches ISA_DEPTH consecutive instructions from DDR into a local instruction RAM.
- It emits a one-cycle load_done pulse, which drives the controller's load-complete exception input.
- While the controller is in its send state, it serves indexed instruction reads to the fetch/decode stage.

---
 rtl/ins_cache_loader.sv | 177 +++++++++++++++++
 tb/tb_ins_cache_loader.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_cache_loader.sv
// Instruction cache fill engine: loads ISA_DEPTH words from DDR into a local RAM and serves indexed reads.
// Optional read-data timeout enabled with `define LOAD_TIMEOUT_EN.
`timescale 1ns/1ps

module ins_cache_loader #(
    parameter int ISA_DEPTH      = 128,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int ISA_WIDTH      = 30,
    parameter int ADDR_STRIDE    = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_start,
    input  logic [DDR_ADDR_WIDTH-1:0]    load_base_addr,
    output logic                         ddr_rd_req,
    output logic [DDR_ADDR_WIDTH-1:0]    ddr_rd_addr,
    input  logic                         ddr_rd_ack,
    input  logic                         ddr_rd_valid,
    input  logic [ISA_WIDTH-1:0]         ddr_rd_data,
    output logic                         load_busy,
    output logic                         load_done,
    output logic                         load_err,
    output logic                         cache_valid,
    output logic [DDR_ADDR_WIDTH-1:0]    cache_base_addr,
    input  logic                         ins_rd_en,
    input  logic [$clog2(ISA_DEPTH)-1:0] ins_rd_idx,
    output logic [ISA_WIDTH-1:0]         ins_rd_data,
    output logic                         ins_rd_valid
);

    localparam int IDX_W = $clog2(ISA_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DATA, S_DONE} state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_cnt;
    logic [DDR_ADDR_WIDTH-1:0] r_base;
    logic                      r_ddr_rd_req;
    logic [DDR_ADDR_WIDTH-1:0] r_ddr_rd_addr;
    logic                      r_load_busy;
    logic                      r_load_done;
    logic                      r_cache_valid;
    logic [DDR_ADDR_WIDTH-1:0] r_cache_base_addr;
    logic [ISA_WIDTH-1:0]      r_ins_rd_data;
    logic                      r_ins_rd_valid;
    logic [ISA_WIDTH-1:0]      r_ram [ISA_DEPTH];

    logic [DDR_ADDR_WIDTH-1:0] w_req_addr;
    logic                      w_last;
    logic                      w_ram_we;

    // Address arithmetic is truncated to the DDR width, so fills wrap at the top of memory.
    assign w_req_addr = r_base + DDR_ADDR_WIDTH'(r_cnt) * DDR_ADDR_WIDTH'(ADDR_STRIDE);
    assign w_last     = (r_cnt == IDX_W'(ISA_DEPTH - 1));
    assign w_ram_we   = (r_state == S_WAIT_DATA) && ddr_rd_valid;

`ifdef LOAD_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_load_err;
    assign load_err = r_load_err;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign load_err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_cnt             <= '0;
            r_base            <= '0;
            r_ddr_rd_req      <= 1'b0;
            r_ddr_rd_addr     <= '0;
            r_load_busy       <= 1'b0;
            r_load_done       <= 1'b0;
            r_cache_valid     <= 1'b0;
            r_cache_base_addr <= '0;
`ifdef LOAD_TIMEOUT_EN
            r_wait_cnt        <= '0;
            r_load_err        <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low each cycle; a branch below raises them for exactly one cycle.
            r_load_done <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            r_load_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_base        <= load_base_addr;
                        r_cnt         <= '0;
                        r_cache_valid <= 1'b0;
                        r_load_busy   <= 1'b1;
`ifdef LOAD_TIMEOUT_EN
                        r_wait_cnt    <= '0;
`endif
                        r_state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    // First REQ cycle registers the address; the request is then held until acked.
                    if (!r_ddr_rd_req) begin
                        r_ddr_rd_req  <= 1'b1;
                        r_ddr_rd_addr <= w_req_addr;
                    end else if (ddr_rd_ack) begin
                        r_ddr_rd_req  <= 1'b0;
                        r_state       <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (ddr_rd_valid) begin
                        if (w_last) begin
                            r_load_busy <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_cnt       <= r_cnt + IDX_W'(1);
`ifdef LOAD_TIMEOUT_EN
                            r_wait_cnt  <= '0;
`endif
                            r_state     <= S_REQ;
                        end
                    end
`ifdef LOAD_TIMEOUT_EN
                    else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_load_err  <= 1'b1;
                        r_load_busy <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + WAIT_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    r_load_done       <= 1'b1;
                    r_cache_valid     <= 1'b1;
                    r_cache_base_addr <= r_base;
                    r_state           <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the instruction RAM has no reset; cache_valid alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[r_cnt] <= ddr_rd_data;
        end
    end

    // Reads are refused while a fill runs; in the load_start cycle the old fill is still served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ins_rd_data  <= '0;
            r_ins_rd_valid <= 1'b0;
        end else begin
            r_ins_rd_valid <= 1'b0;
            if (ins_rd_en && r_cache_valid && !r_load_busy) begin
                r_ins_rd_data  <= r_ram[ins_rd_idx];
                r_ins_rd_valid <= 1'b1;
            end
        end
    end

    assign ddr_rd_req      = r_ddr_rd_req;
    assign ddr_rd_addr     = r_ddr_rd_addr;
    assign load_busy       = r_load_busy;
    assign load_done       = r_load_done;
    assign cache_valid     = r_cache_valid;
    assign cache_base_addr = r_cache_base_addr;
    assign ins_rd_data     = r_ins_rd_data;
    assign ins_rd_valid    = r_ins_rd_valid;

endmodule

// File: tb/tb_ins_cache_loader.sv
// Scoreboard bench for ins_cache_loader: randomized DDR responder, address/read/event monitors.
// Define LOAD_TIMEOUT_EN to also exercise the read-data timeout.
`timescale 1ns/1ps

module tb_ins_cache_loader;

    localparam int ISA_DEPTH = 128;
    localparam int AW        = 28;
    localparam int IW        = 30;
    localparam int STRIDE    = 8;
    localparam int IDXW      = $clog2(ISA_DEPTH);
`ifdef LOAD_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            load_start;
    logic [AW-1:0]   load_base_addr;
    logic            ddr_rd_req;
    logic [AW-1:0]   ddr_rd_addr;
    logic            ddr_rd_ack;
    logic            ddr_rd_valid;
    logic [IW-1:0]   ddr_rd_data;
    logic            load_busy;
    logic            load_done;
    logic            load_err;
    logic            cache_valid;
    logic [AW-1:0]   cache_base_addr;
    logic            ins_rd_en;
    logic [IDXW-1:0] ins_rd_idx;
    logic [IW-1:0]   ins_rd_data;
    logic            ins_rd_valid;

    ins_cache_loader #(
        .ISA_DEPTH(ISA_DEPTH), .DDR_ADDR_WIDTH(AW), .ISA_WIDTH(IW),
        .ADDR_STRIDE(STRIDE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_base_addr(load_base_addr),
        .ddr_rd_req(ddr_rd_req), .ddr_rd_addr(ddr_rd_addr),
        .ddr_rd_ack(ddr_rd_ack), .ddr_rd_valid(ddr_rd_valid), .ddr_rd_data(ddr_rd_data),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .cache_valid(cache_valid), .cache_base_addr(cache_base_addr),
        .ins_rd_en(ins_rd_en), .ins_rd_idx(ins_rd_idx),
        .ins_rd_data(ins_rd_data), .ins_rd_valid(ins_rd_valid)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no/unexpected event, expected event within bound (t=%0t)", name, $time);
    endtask

    // Reference model state
    typedef struct packed {
        logic          v;
        logic [IW-1:0] d;
    } rd_exp_t;

    logic [AW-1:0] exp_addr_q[$];
    rd_exp_t       rd_q[$];
    logic [IW-1:0] fill_words[$];
    logic [IW-1:0] cache_model [ISA_DEPTH];
    logic [IW-1:0] last_rd = '0;
    int            done_cnt = 0;
    int            err_cnt  = 0;
    int unsigned   done_cyc = 0;
    int unsigned   err_cyc  = 0;
    int unsigned   start_cyc = 0;

    // DDR responder knobs
    int          ack_dly  = 0;
    int          val_dly  = 0;
    bit          spurious = 1'b0;
    int          withhold = -1;
    int          n_words  = 0;
    int unsigned withhold_ack_cyc = 0;

    // Behavioural DDR: acks a held request after ack_dly stall cycles, returns data val_dly cycles later.
    initial begin : ddr_model
        int phase;
        int d;
        phase = 0;
        d = 0;
        ddr_rd_ack   = 1'b0;
        ddr_rd_valid = 1'b0;
        ddr_rd_data  = '0;
        forever begin
            @(posedge clk); #1;
            ddr_rd_ack   = 1'b0;
            ddr_rd_valid = 1'b0;
            if (rst) begin
                phase = 0;
                continue;
            end
            if (phase == 0 && ddr_rd_req) begin
                d = ack_dly;
                phase = 1;
            end
            if (phase == 1) begin
                if (d == 0) begin
                    ddr_rd_ack = 1'b1;
                    phase = 2;
                    d = val_dly;
                    if (n_words == withhold) withhold_ack_cyc = cyc;
                end else begin
                    d--;
                end
                if (spurious) begin
                    ddr_rd_valid = 1'b1;
                    ddr_rd_data  = IW'($urandom);
                end
            end else if (phase == 2) begin
                if (n_words == withhold) begin
                    phase = 0;
                end else if (d == 0) begin
                    ddr_rd_valid = 1'b1;
                    ddr_rd_data  = IW'($urandom);
                    fill_words.push_back(ddr_rd_data);
                    n_words++;
                    phase = 0;
                end else begin
                    d--;
                end
            end
        end
    end

    // Request monitor: accepted addresses against the expected sequence, stalled addresses held.
    initial begin : addr_mon
        logic          held;
        logic [AW-1:0] held_addr;
        held = 1'b0;
        held_addr = '0;
        forever begin
            @(negedge clk);
            if (ddr_rd_req && ddr_rd_ack) begin
                if (exp_addr_q.size() == 0) fail_now("unexpected_req");
                else check("req_addr", ddr_rd_addr, exp_addr_q.pop_front());
                held = 1'b0;
            end else if (ddr_rd_req) begin
                if (held) check("addr_stable", ddr_rd_addr, held_addr);
                else begin
                    held = 1'b1;
                    held_addr = ddr_rd_addr;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // Read monitor: one expectation per strobed cycle, otherwise valid must stay low.
    initial begin : rd_mon
        logic    en_s;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            en_s = ins_rd_en;
            @(negedge clk);
            if (en_s) begin
                if (rd_q.size() == 0) fail_now("rd_unexpected");
                else begin
                    e = rd_q.pop_front();
                    check("rd_valid", ins_rd_valid, e.v);
                    check("rd_data", ins_rd_data, e.d);
                end
            end else begin
                check("rd_idle_valid", ins_rd_valid, 1'b0);
            end
        end
    end

    initial begin : evt_mon
        forever begin
            @(negedge clk);
            if (load_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (load_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic read_drive(input int idx, input bit exp_v);
        ins_rd_en  = 1'b1;
        ins_rd_idx = IDXW'(idx);
        if (exp_v) begin
            last_rd = cache_model[idx];
            rd_q.push_back(rd_exp_t'{v: 1'b1, d: cache_model[idx]});
        end else begin
            rd_q.push_back(rd_exp_t'{v: 1'b0, d: last_rd});
        end
    endtask

    task automatic read(input int idx, input bit exp_v);
        read_drive(idx, exp_v);
        tick();
        ins_rd_en = 1'b0;
    endtask

    task automatic start_fill(input logic [AW-1:0] base);
        logic [AW-1:0] a;
        fill_words.delete();
        n_words = 0;
        for (int k = 0; k < ISA_DEPTH; k++) begin
            a = base + AW'(k * STRIDE);
            exp_addr_q.push_back(a);
        end
        load_start     = 1'b1;
        load_base_addr = base;
        start_cyc      = cyc;
        tick();
        load_start = 1'b0;
        ins_rd_en  = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget);
        int b;
        b = 0;
        while (done_cnt == prev && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (done_cnt == prev) fail_now("done_timeout");
        tick();
        for (int k = 0; k < ISA_DEPTH; k++)
            cache_model[k] = (k < fill_words.size()) ? fill_words[k] : '0;
    endtask

    task automatic wait_words(input int n);
        int b;
        b = 0;
        while (n_words < n && b < 3000) begin
            tick();
            b++;
        end
        if (n_words < n) fail_now("words_timeout");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ddr_rd_req"}, ddr_rd_req, 1'b0);
        check({tag, "_ddr_rd_addr"}, ddr_rd_addr, '0);
        check({tag, "_load_busy"}, load_busy, 1'b0);
        check({tag, "_load_done"}, load_done, 1'b0);
        check({tag, "_load_err"}, load_err, 1'b0);
        check({tag, "_cache_valid"}, cache_valid, 1'b0);
        check({tag, "_cache_base"}, cache_base_addr, '0);
        check({tag, "_ins_rd_data"}, ins_rd_data, '0);
        check({tag, "_ins_rd_valid"}, ins_rd_valid, 1'b0);
    endtask

    initial begin : stim
        int            prev;
        logic [AW-1:0] base_b;
        logic [AW-1:0] base_e;

        rst            = 1'b1;
        load_start     = 1'b0;
        load_base_addr = '0;
        ins_rd_en      = 1'b0;
        ins_rd_idx     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        read(3, 1'b0);
        tick();

        // Fill A: zero-wait DDR
        prev = done_cnt;
        start_fill(28'h0000100);
        repeat (20) tick();
        check("busy_mid_fill", load_busy, 1'b1);
        read(10, 1'b0);
        read(20, 1'b0);
        wait_done(prev, 1000);
        check("fill_latency", done_cyc - start_cyc, 386);
        tick();
        check("done_once_a", done_cnt - prev, 1);
        check("cache_valid_a", cache_valid, 1'b1);
        check("cache_base_a", cache_base_addr, 28'h0000100);
        check("busy_after_a", load_busy, 1'b0);
        check("reqs_drained_a", exp_addr_q.size(), 0);
        read(0, 1'b1);
        read(5, 1'b1);
        read(127, 1'b1);
        for (int i = 0; i < 8; i++) read($urandom_range(0, ISA_DEPTH - 1), 1'b1);
        tick();

        // Fill B: back-pressure, spurious valids, ignored mid-fill start
        ack_dly  = 3;
        val_dly  = 5;
        spurious = 1'b1;
        base_b   = AW'($urandom);
        prev     = done_cnt;
        read_drive(7, 1'b1);
        start_fill(base_b);
        wait_words(20);
        load_start     = 1'b1;
        load_base_addr = 28'h5555550;
        tick();
        load_start = 1'b0;
        read(1, 1'b0);
        wait_done(prev, 5000);
        tick();
        check("done_once_b", done_cnt - prev, 1);
        check("cache_valid_b", cache_valid, 1'b1);
        check("cache_base_b", cache_base_addr, base_b);
        check("reqs_drained_b", exp_addr_q.size(), 0);
        for (int i = 0; i < ISA_DEPTH; i++) read(i, 1'b1);
        ack_dly  = 0;
        val_dly  = 0;
        spurious = 1'b0;
        tick();

        // Fill C: address wrap
        prev = done_cnt;
        start_fill(28'hFFFFFF8);
        wait_done(prev, 1000);
        tick();
        check("cache_base_c", cache_base_addr, 28'hFFFFFF8);
        check("reqs_drained_c", exp_addr_q.size(), 0);
        read(0, 1'b1);
        read(1, 1'b1);
        read(127, 1'b1);
        tick();

        // Fill D: reset after 40 words
        prev = done_cnt;
        start_fill(AW'($urandom));
        wait_words(40);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        exp_addr_q.delete();
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) tick();
        check("no_done_on_abort", done_cnt, prev);
        check("cache_valid_abort", cache_valid, 1'b0);
        read(4, 1'b0);

        // Fill E: fresh fill after reset, random small delays
        ack_dly = $urandom_range(0, 2);
        val_dly = $urandom_range(0, 2);
        base_e  = AW'($urandom);
        prev    = done_cnt;
        start_fill(base_e);
        wait_done(prev, 3000);
        tick();
        check("done_once_e", done_cnt - prev, 1);
        check("cache_valid_e", cache_valid, 1'b1);
        check("cache_base_e", cache_base_addr, base_e);
        for (int i = 0; i < 6; i++) read($urandom_range(0, ISA_DEPTH - 1), 1'b1);
        ack_dly = 0;
        val_dly = 0;

`ifdef LOAD_TIMEOUT_EN
        // Fill F: data for word 3 never returned
        begin
            int b;
            b = 0;
            withhold = 3;
            prev = done_cnt;
            start_fill(28'h0000200);
            while (err_cnt == 0 && b < 2000) begin
                @(negedge clk);
                b++;
            end
            if (err_cnt == 0) fail_now("err_timeout");
            tick();
            check("err_latency", err_cyc - (withhold_ack_cyc + 1), TMO);
            check("err_once", err_cnt, 1);
            check("cache_valid_tmo", cache_valid, 1'b0);
            check("busy_tmo", load_busy, 1'b0);
            check("req_tmo", ddr_rd_req, 1'b0);
            check("no_done_tmo", done_cnt, prev);
            exp_addr_q.delete();
            withhold = -1;
            read(0, 1'b0);
        end
`else
        check("no_err_pulses", err_cnt, 0);
`endif

        repeat (3) tick();
        check("rd_queue_drained", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
